// File: rtl/sp_word_assembler_if.sv
// Handshake bundle between the shift stage, the word assembler and its consumer.
// Optional out_parity signal is present when SP_WORD_ASSEMBLER_PARITY_EN is defined.
interface sp_word_assembler_if #(
    parameter int N = 4,
    parameter int M = 2
);
    localparam int W  = M * N;
    localparam int LW = $clog2(M + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          sync;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [LW-1:0] level;
`ifdef SP_WORD_ASSEMBLER_PARITY_EN
    logic          out_parity;
`endif

    modport slave (
        input  in_valid, in_data, sync, out_ready,
        output in_ready, out_valid, out_data, level
`ifdef SP_WORD_ASSEMBLER_PARITY_EN
        , output out_parity
`endif
    );

    modport master (
        output in_valid, in_data, sync, out_ready,
        input  in_ready, out_valid, out_data, level
`ifdef SP_WORD_ASSEMBLER_PARITY_EN
        , input out_parity
`endif
    );
endinterface

// File: rtl/sp_word_assembler.sv
// Groups N-bit input groups into M*N-bit words with a one-word park buffer behind the output register.
// Define SP_WORD_ASSEMBLER_PARITY_EN to add an even-parity bit registered alongside out_data.
module sp_word_assembler #(
    parameter int N = 4,
    parameter int M = 2
) (
    input logic               clk,
    input logic               reset,
    sp_word_assembler_if.slave s
);
    localparam int W  = M * N;
    localparam int LW = $clog2(M + 1);
    localparam logic [LW-1:0] CNT_FULL = LW'(M);
    localparam logic [LW-1:0] CNT_LAST = LW'(M - 1);

    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_out_data;
    logic [LW-1:0] r_cnt;
    logic          r_out_valid;
`ifdef SP_WORD_ASSEMBLER_PARITY_EN
    logic          r_out_parity;
`endif

    logic          w_parked;
    logic          w_accept;
    logic          w_pop;
    logic          w_slot_free;
    logic [W-1:0]  w_next;

    // in_ready depends only on the counter, so there is no path from out_ready
    assign w_parked    = (r_cnt == CNT_FULL);
    assign w_accept    = s.in_valid && !w_parked;
    assign w_pop       = r_out_valid && s.out_ready;
    assign w_slot_free = !r_out_valid || w_pop;
    assign w_next      = {r_acc[W-N-1:0], s.in_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
`ifdef SP_WORD_ASSEMBLER_PARITY_EN
            r_out_parity <= 1'b0;
`endif
        end else begin
            if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            if (w_parked) begin
                // sync is ignored while a complete word waits in the accumulator
                if (w_pop) begin
                    r_out_data  <= r_acc;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
`ifdef SP_WORD_ASSEMBLER_PARITY_EN
                    r_out_parity <= ^r_acc;
`endif
                end
            end else if (w_accept) begin
                r_acc <= w_next;
                if (s.sync) begin
                    r_cnt <= LW'(1);
                end else if (r_cnt == CNT_LAST) begin
                    if (w_slot_free) begin
                        r_out_data  <= w_next;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
`ifdef SP_WORD_ASSEMBLER_PARITY_EN
                        r_out_parity <= ^w_next;
`endif
                    end else begin
                        r_cnt <= CNT_FULL;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (s.sync) begin
                r_cnt <= '0;
            end
        end
    end

    assign s.in_ready  = !w_parked;
    assign s.out_valid = r_out_valid;
    assign s.out_data  = r_out_data;
    assign s.level     = r_cnt;
`ifdef SP_WORD_ASSEMBLER_PARITY_EN
    assign s.out_parity = r_out_parity;
`endif
endmodule

// File: tb/tb_sp_word_assembler.sv
// Self-checking bench for sp_word_assembler: queue-based word model plus directed literal checks.
// Parity checks are compiled in when SP_WORD_ASSEMBLER_PARITY_EN is defined.
module tb_sp_word_assembler;
    localparam int N  = 4;
    localparam int M  = 2;
    localparam int W  = M * N;
    localparam int LW = $clog2(M + 1);

    logic clk;
    logic reset;

    sp_word_assembler_if #(.N(N), .M(M)) bus ();

    sp_word_assembler #(.N(N), .M(M)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: groups of the word being built, and complete words not yet taken
    logic [N-1:0] m_partial[$];
    logic [W-1:0] m_pend[$];
    logic [W-1:0] m_od;
    bit           m_live = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        int  n0;
        bit  acc;
        logic [W-1:0] word;
        if (reset) begin
            m_partial.delete();
            m_pend.delete();
            m_od   = '0;
            m_live = 1;
        end else if (m_live) begin
            n0  = m_pend.size();
            acc = bus.in_valid && (n0 < 2);
            if (n0 > 0 && bus.out_ready) void'(m_pend.pop_front());
            if (acc) begin
                if (bus.sync) m_partial.delete();
                m_partial.push_back(bus.in_data);
                if (m_partial.size() == M) begin
                    word = '0;
                    foreach (m_partial[i]) word = (word << N) | W'(m_partial[i]);
                    m_pend.push_back(word);
                    m_partial.delete();
                end
            end else if (bus.sync && n0 < 2) begin
                m_partial.delete();
            end
            if (m_pend.size() > 0) m_od = m_pend[0];
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("out_valid", 32'(bus.out_valid), 32'(m_pend.size() > 0));
            chk("in_ready", 32'(bus.in_ready), 32'(m_pend.size() < 2));
            chk("level", 32'(bus.level), (m_pend.size() == 2) ? 32'(M) : 32'(m_partial.size()));
            chk("out_data", 32'(bus.out_data), 32'(m_od));
`ifdef SP_WORD_ASSEMBLER_PARITY_EN
            chk("out_parity", 32'(bus.out_parity), 32'(^m_od));
`endif
        end
    end

    task automatic drive(input bit v, input logic [N-1:0] d, input bit sy, input bit rdy, input bit rst);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.sync      = sy;
        bus.out_ready = rdy;
        reset         = rst;
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.sync = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        drive(0, 4'h0, 0, 1, 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_ready", 32'(bus.in_ready), 1);

        // 0xA, 0xB -> 0xAB for exactly one cycle
        drive(1, 4'hA, 0, 1, 0);
        drive(1, 4'hB, 0, 1, 0);
        drive(0, 4'h0, 0, 1, 0);
        chk("ab_data", 32'(bus.out_data), 32'hAB);
        chk("ab_valid", 32'(bus.out_valid), 1);
        drive(0, 4'h0, 0, 1, 0);
        chk("ab_gone", 32'(bus.out_valid), 0);

        // back-to-back stream
        drive(1, 4'h1, 0, 1, 0);
        drive(1, 4'h2, 0, 1, 0);
        drive(1, 4'h3, 0, 1, 0);
        chk("s12", 32'(bus.out_data), 32'h12);
        chk("s_ready", 32'(bus.in_ready), 1);
        drive(1, 4'h4, 0, 1, 0);
        drive(1, 4'h5, 0, 1, 0);
        chk("s34", 32'(bus.out_data), 32'h34);
        drive(1, 4'h6, 0, 1, 0);
        drive(0, 4'h0, 0, 1, 0);
        chk("s56", 32'(bus.out_data), 32'h56);

        // back-pressure with a parked word
        drive(1, 4'h1, 0, 0, 0);
        drive(1, 4'h2, 0, 0, 0);
        drive(1, 4'h3, 0, 0, 0);
        drive(1, 4'h4, 0, 0, 0);
        drive(0, 4'h0, 0, 0, 0);
        chk("bp_data", 32'(bus.out_data), 32'h12);
        chk("bp_level", 32'(bus.level), 2);
        chk("bp_ready", 32'(bus.in_ready), 0);
        drive(0, 4'h0, 0, 1, 0);
        drive(0, 4'h0, 0, 0, 0);
        chk("bp_data2", 32'(bus.out_data), 32'h34);
        chk("bp_level2", 32'(bus.level), 0);
        chk("bp_ready2", 32'(bus.in_ready), 1);
        drive(0, 4'h0, 0, 1, 0);

        // sync realign drops 0x7
        drive(1, 4'h7, 0, 1, 0);
        drive(1, 4'h8, 1, 1, 0);
        drive(1, 4'h9, 0, 1, 0);
        drive(0, 4'h0, 0, 1, 0);
        chk("sync_data", 32'(bus.out_data), 32'h89);
        chk("sync_valid", 32'(bus.out_valid), 1);

        // reset with a pending word and a partial group
        drive(1, 4'h1, 0, 0, 0);
        drive(1, 4'h2, 0, 0, 0);
        drive(1, 4'hC, 0, 0, 0);
        drive(0, 4'h0, 0, 0, 1);
        drive(0, 4'h0, 0, 1, 0);
        chk("mr_valid", 32'(bus.out_valid), 0);
        chk("mr_level", 32'(bus.level), 0);
        chk("mr_data", 32'(bus.out_data), 0);
        drive(1, 4'hD, 0, 1, 0);
        drive(1, 4'hE, 0, 1, 0);
        drive(0, 4'h0, 0, 1, 0);
        chk("mr_de", 32'(bus.out_data), 32'hDE);

`ifdef SP_WORD_ASSEMBLER_PARITY_EN
        drive(1, 4'h1, 0, 1, 0);
        drive(1, 4'h3, 0, 1, 0);
        drive(0, 4'h0, 0, 1, 0);
        chk("par13", 32'(bus.out_parity), 1);
        drive(1, 4'h3, 0, 1, 0);
        drive(1, 4'h3, 0, 1, 0);
        drive(0, 4'h0, 0, 1, 0);
        chk("par33", 32'(bus.out_parity), 0);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99) < 70, 4'($urandom), $urandom_range(99) < 5,
                  $urandom_range(99) < 60, $urandom_range(199) < 1);
        end
        drive(0, 4'h0, 0, 1, 0);
        drive(0, 4'h0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sp_word_assembler.md
Name: sp_word_assembler

Overview:
- Sits directly downstream of the serial-to-parallel shift stage and groups incoming N-bit groups into framed M*N-bit words.
- Accepts one N-bit group per cycle under a valid/ready handshake and tracks group position with a counter.
- Double-buffers: one word assembles in an accumulator while the previous word is held on the output under valid/ready.
- Supports a sync input that realigns word boundaries, and sustains full throughput when the output is not back-pressured.

Parameters:
- N, 4, bits per input group.
- M, 2, groups per output word (M >= 2); output word is M*N bits.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high; clock clk.
- in_valid  input  1  in_data holds a group.
- in_ready  output  1  block can accept a group this cycle.
- in_data  input  N  group; first group of a word lands in MS position.
- sync  input  1  word-boundary realign strobe.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  M*N  assembled word.
- level  output  clog2(M+1)  groups currently held in the accumulator (0..M).

Behaviour:
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Reset (dominates everything, including mid-word and pending output):
  - acc=0, cnt=0, out_valid=0, out_data=0.
  - in_ready=1 from the cycle after reset deasserts.
- Accumulator is a shift register: on accept, acc <= {acc[(M-1)*N-1:0], in_data}; cnt increments.
- cnt is 0..M-1 while filling. cnt==M means a complete word is parked in acc.
- in_ready = (cnt != M), purely from registered state (no in_ready-from-out_ready combinational path).
- Completion: accept while cnt==M-1.
  - If slot free (!out_valid || pop): out_data <= completed word, out_valid <= 1, cnt <= 0.
  - Else: acc <= completed word, cnt <= M (parked); in_ready drops.
- Parked (cnt==M) and pop: out_data <= acc, out_valid stays 1, cnt <= 0; in_ready returns next cycle.
- Pop with no new word: out_valid <= 0; out_data holds its last value.
- Latency: the word is visible on out_data/out_valid the cycle after its last group is accepted.
- Throughput: one group per cycle while out_ready=1.
- out_data must not change while out_valid && !out_ready.
- sync:
  - cnt in 1..M-1: partial word is discarded, cnt <= 0.
  - cnt==M: the parked word is kept; sync is ignored.
  - sync coincident with accept (cnt<M): the accepted group becomes group 0 of a new word (acc low N bits = in_data, cnt <= 1).
  - For M... with cnt<M and accept, a word never completes in the sync cycle.
- level = cnt.

Optional Feature:
- Macro SP_WORD_ASSEMBLER_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR of all out_data bits (even parity).
  - Registered in the same cycle as out_data; reset 0; held stable with out_data under back-pressure.
- Undefined: port absent; behaviour otherwise identical.

Test Plan (N=4, M=2):
- Reset, out_ready=1, send 0xA then 0xB on consecutive cycles -> out_data=0xAB, out_valid=1 the cycle after 0xB is accepted, for exactly 1 cycle.
- Stream 0x1..0x6 back-to-back with out_ready=1 -> words 0x12, 0x34, 0x56 on alternate cycles; in_ready stays 1 throughout.
- out_ready=0, send 0x1,0x2,0x3,0x4:
  - out_data=0x12 held, level=2, in_ready=0.
  - Raise out_ready 1 cycle -> next cycle out_data=0x34, level=0, in_ready=1.
- Send 0x7, pulse sync together with 0x8, then send 0x9 -> out_data=0x89; 0x7 is never emitted.
- Send 0xC, then assert reset for 1 cycle while out_valid=1 -> out_valid=0, level=0, out_data=0. Then send 0xD,0xE -> out_data=0xDE.
- With SP_WORD_ASSEMBLER_PARITY_EN defined: word 0x13 -> out_parity=1; word 0x33 -> out_parity=0.
